// File: rtl/reg_rename_pkg.sv
// Shared types and constants for the reg_rename dispatch stage.
package reg_rename_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned NREG   = 1 << RD_W;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [OP_W-1:0] OP_ADD = 6'd1;
    localparam logic [OP_W-1:0] OP_SUB = 6'd2;
    localparam logic [OP_W-1:0] OP_LW  = 6'd3;
    localparam logic [OP_W-1:0] OP_SW  = 6'd4;
    localparam logic [OP_W-1:0] OP_SB  = 6'd5;
    localparam logic [OP_W-1:0] OP_BEQ = 6'd6;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [PC_W-1:0]   pc;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] v1;
        logic [DATA_W-1:0] v2;
        logic [PC_W-1:0]   q1;
        logic [PC_W-1:0]   q2;
        logic              busy1;
        logic              busy2;
    } dispatch_pkt_t;

endpackage

// File: rtl/reg_rename_if.sv
// Instruction-queue, ROB-dispatch and ROB-commit signals of the rename stage.
interface reg_rename_if;
    import reg_rename_pkg::*;

    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [OP_W-1:0]   in_op_i;
    logic [PC_W-1:0]   in_pc_i;
    logic [RD_W-1:0]   in_rs1_i;
    logic [RD_W-1:0]   in_rs2_i;
    logic [RD_W-1:0]   in_rd_i;
    logic [DATA_W-1:0] in_imm_i;
    logic              rob_stall_i;
    logic              out_valid_o;
    logic [OP_W-1:0]   out_op_o;
    logic [PC_W-1:0]   out_pc_o;
    logic [RD_W-1:0]   out_rd_o;
    logic [DATA_W-1:0] out_imm_o;
    logic [DATA_W-1:0] out_v1_o;
    logic [DATA_W-1:0] out_v2_o;
    logic [PC_W-1:0]   out_q1_o;
    logic [PC_W-1:0]   out_q2_o;
    logic              out_busy1_o;
    logic              out_busy2_o;
    logic              commit_valid_i;
    logic [RD_W-1:0]   commit_rd_i;
    logic [PC_W-1:0]   commit_pc_i;
    logic [DATA_W-1:0] commit_data_i;

    modport slave (
        input  flush_i, in_valid_i, in_op_i, in_pc_i, in_rs1_i, in_rs2_i, in_rd_i, in_imm_i,
        input  rob_stall_i, commit_valid_i, commit_rd_i, commit_pc_i, commit_data_i,
        output in_ready_o, out_valid_o, out_op_o, out_pc_o, out_rd_o, out_imm_o,
        output out_v1_o, out_v2_o, out_q1_o, out_q2_o, out_busy1_o, out_busy2_o
    );

    modport master (
        output flush_i, in_valid_i, in_op_i, in_pc_i, in_rs1_i, in_rs2_i, in_rd_i, in_imm_i,
        output rob_stall_i, commit_valid_i, commit_rd_i, commit_pc_i, commit_data_i,
        input  in_ready_o, out_valid_o, out_op_o, out_pc_o, out_rd_o, out_imm_o,
        input  out_v1_o, out_v2_o, out_q1_o, out_q2_o, out_busy1_o, out_busy2_o
    );

endinterface

// File: rtl/reg_rename_read.sv
// Combinational operand lookup for one source register.
// REG_COMMIT_BYPASS_EN forwards a same-cycle matching commit; otherwise it raises a hazard.
module reg_rename_read
    import reg_rename_pkg::*;
(
    input  logic [RD_W-1:0]   rs_i,
    input  logic              busy_i,
    input  logic [PC_W-1:0]   tag_i,
    input  logic [DATA_W-1:0] rf_i,
    input  logic              commit_valid_i,
    input  logic [RD_W-1:0]   commit_rd_i,
    input  logic [PC_W-1:0]   commit_pc_i,
`ifdef REG_COMMIT_BYPASS_EN
    input  logic [DATA_W-1:0] commit_data_i,
`endif
    output logic [DATA_W-1:0] v_c_o,
    output logic [PC_W-1:0]   q_c_o,
    output logic              busy_c_o,
    output logic              hazard_c_o
);

    logic hit_c;

    assign hit_c = commit_valid_i && (commit_rd_i == rs_i) && (tag_i == commit_pc_i);

    always_comb begin
        v_c_o      = '0;
        q_c_o      = '0;
        busy_c_o   = FALSE;
        hazard_c_o = FALSE;
        if (rs_i != '0) begin
            if (busy_i && hit_c) begin
`ifdef REG_COMMIT_BYPASS_EN
                v_c_o      = commit_data_i;
`else
                hazard_c_o = TRUE;
`endif
            end else if (busy_i) begin
                busy_c_o = TRUE;
                q_c_o    = tag_i;
            end else begin
                v_c_o = rf_i;
            end
        end
    end

endmodule

// File: rtl/reg_rename.sv
// Dispatch stage: reads regfile/rename table, renames rd, emits a registered ROB packet.
// Optional macro REG_COMMIT_BYPASS_EN enables commit-to-dispatch forwarding.
module reg_rename
    import reg_rename_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    reg_rename_if.slave  bus
);

    logic [DATA_W-1:0] rf_q  [NREG];
    logic [DATA_W-1:0] rf_d  [NREG];
    logic [PC_W-1:0]   tag_q [NREG];
    logic [PC_W-1:0]   tag_d [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    dispatch_pkt_t     pkt_q, pkt_d;
    logic              valid_q, valid_d;

    logic [DATA_W-1:0] v1_c, v2_c;
    logic [PC_W-1:0]   q1_c, q2_c;
    logic              busy1_c, busy2_c, hz1_c, hz2_c;
    logic              ready_c, accept_c;

    reg_rename_read u_read1 (
        .rs_i           (bus.in_rs1_i),
        .busy_i         (busy_q[bus.in_rs1_i]),
        .tag_i          (tag_q[bus.in_rs1_i]),
        .rf_i           (rf_q[bus.in_rs1_i]),
        .commit_valid_i (bus.commit_valid_i),
        .commit_rd_i    (bus.commit_rd_i),
        .commit_pc_i    (bus.commit_pc_i),
`ifdef REG_COMMIT_BYPASS_EN
        .commit_data_i  (bus.commit_data_i),
`endif
        .v_c_o          (v1_c),
        .q_c_o          (q1_c),
        .busy_c_o       (busy1_c),
        .hazard_c_o     (hz1_c)
    );

    reg_rename_read u_read2 (
        .rs_i           (bus.in_rs2_i),
        .busy_i         (busy_q[bus.in_rs2_i]),
        .tag_i          (tag_q[bus.in_rs2_i]),
        .rf_i           (rf_q[bus.in_rs2_i]),
        .commit_valid_i (bus.commit_valid_i),
        .commit_rd_i    (bus.commit_rd_i),
        .commit_pc_i    (bus.commit_pc_i),
`ifdef REG_COMMIT_BYPASS_EN
        .commit_data_i  (bus.commit_data_i),
`endif
        .v_c_o          (v2_c),
        .q_c_o          (q2_c),
        .busy_c_o       (busy2_c),
        .hazard_c_o     (hz2_c)
    );

    assign ready_c        = !bus.rob_stall_i && !bus.flush_i && !hz1_c && !hz2_c;
    assign accept_c       = bus.in_valid_i && ready_c;
    assign bus.in_ready_o = ready_c;

    // Output packet: flush kills it, stall holds it, otherwise it follows accept.
    always_comb begin
        pkt_d   = pkt_q;
        valid_d = valid_q;
        if (bus.flush_i) begin
            valid_d = FALSE;
        end else if (!bus.rob_stall_i) begin
            valid_d = accept_c;
            if (accept_c) begin
                pkt_d.op    = bus.in_op_i;
                pkt_d.pc    = bus.in_pc_i;
                pkt_d.rd    = bus.in_rd_i;
                pkt_d.imm   = bus.in_imm_i;
                pkt_d.v1    = v1_c;
                pkt_d.v2    = v2_c;
                pkt_d.q1    = q1_c;
                pkt_d.q2    = q2_c;
                pkt_d.busy1 = busy1_c;
                pkt_d.busy2 = busy2_c;
            end
        end
    end

    // Regfile and rename table; a same-cycle rename overrides the commit's busy clear.
    always_comb begin
        rf_d   = rf_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        if (bus.flush_i) begin
            busy_d = '0;
        end else begin
            if (bus.commit_valid_i && (bus.commit_rd_i != '0)) begin
                rf_d[bus.commit_rd_i] = bus.commit_data_i;
                if (tag_q[bus.commit_rd_i] == bus.commit_pc_i) begin
                    busy_d[bus.commit_rd_i] = FALSE;
                end
            end
            if (accept_c && (bus.in_rd_i != '0)) begin
                busy_d[bus.in_rd_i] = TRUE;
                tag_d[bus.in_rd_i]  = bus.in_pc_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_q   <= '0;
            valid_q <= FALSE;
            busy_q  <= '0;
            for (int i = 0; i < int'(NREG); i++) begin
                rf_q[i]  <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            pkt_q   <= pkt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            for (int i = 0; i < int'(NREG); i++) begin
                rf_q[i]  <= rf_d[i];
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign bus.out_valid_o = valid_q;
    assign bus.out_op_o    = pkt_q.op;
    assign bus.out_pc_o    = pkt_q.pc;
    assign bus.out_rd_o    = pkt_q.rd;
    assign bus.out_imm_o   = pkt_q.imm;
    assign bus.out_v1_o    = pkt_q.v1;
    assign bus.out_v2_o    = pkt_q.v2;
    assign bus.out_q1_o    = pkt_q.q1;
    assign bus.out_q2_o    = pkt_q.q2;
    assign bus.out_busy1_o = pkt_q.busy1;
    assign bus.out_busy2_o = pkt_q.busy2;

endmodule

// File: tb/tb_reg_rename.sv
// Directed self-checking bench for reg_rename; expectations follow REG_COMMIT_BYPASS_EN.
module tb_reg_rename;
    import reg_rename_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    reg_rename_if bus ();

    reg_rename dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] imm);
        bus.in_valid_i = 1'b1;
        bus.in_op_i    = OP_ADD;
        bus.in_pc_i    = pc;
        bus.in_rs1_i   = rs1;
        bus.in_rs2_i   = rs2;
        bus.in_rd_i    = rd;
        bus.in_imm_i   = imm;
    endtask

    task automatic commit(input logic v, input logic [4:0] rd, input logic [31:0] pc,
                          input logic [31:0] data);
        bus.commit_valid_i = v;
        bus.commit_rd_i    = rd;
        bus.commit_pc_i    = pc;
        bus.commit_data_i  = data;
    endtask

    initial begin
        bus.flush_i     = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.in_op_i     = '0;
        bus.in_pc_i     = '0;
        bus.in_rs1_i    = '0;
        bus.in_rs2_i    = '0;
        bus.in_rd_i     = '0;
        bus.in_imm_i    = '0;
        bus.rob_stall_i = 1'b0;
        commit(1'b0, 5'd0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_pc", 64'(bus.out_pc_o), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_ready", 64'(bus.in_ready_o), 64'd1);

        // First dispatch: x0 sources, rename x5
        drive(32'h100, 5'd0, 5'd0, 5'd5, 32'h11);
        tick();
        check("d1_valid", 64'(bus.out_valid_o), 64'd1);
        check("d1_pc", 64'(bus.out_pc_o), 64'h100);
        check("d1_rd", 64'(bus.out_rd_o), 64'd5);
        check("d1_imm", 64'(bus.out_imm_o), 64'h11);
        check("d1_op", 64'(bus.out_op_o), 64'(OP_ADD));
        check("d1_v1", 64'(bus.out_v1_o), 64'd0);
        check("d1_busy", 64'({bus.out_busy1_o, bus.out_busy2_o}), 64'd0);

        // Dependent read of x5
        drive(32'h104, 5'd5, 5'd0, 5'd6, 32'h0);
        tick();
        check("d2_busy1", 64'(bus.out_busy1_o), 64'd1);
        check("d2_q1", 64'(bus.out_q1_o), 64'h100);
        check("d2_v1", 64'(bus.out_v1_o), 64'd0);
        check("d2_busy2", 64'(bus.out_busy2_o), 64'd0);
        check("d2_q2", 64'(bus.out_q2_o), 64'd0);

        // Commit x5 while dispatching a reader of x5
        drive(32'h108, 5'd5, 5'd0, 5'd8, 32'h0);
        commit(1'b1, 5'd5, 32'h100, 32'h2A);
        #1;
`ifdef REG_COMMIT_BYPASS_EN
        check("byp_ready", 64'(bus.in_ready_o), 64'd1);
        tick();
        commit(1'b0, 5'd0, 32'h0, 32'h0);
`else
        check("hz_ready", 64'(bus.in_ready_o), 64'd0);
        tick();
        commit(1'b0, 5'd0, 32'h0, 32'h0);
        check("hz_valid", 64'(bus.out_valid_o), 64'd0);
        #1;
        check("hz_ready2", 64'(bus.in_ready_o), 64'd1);
        tick();
`endif
        check("byp_valid", 64'(bus.out_valid_o), 64'd1);
        check("byp_pc", 64'(bus.out_pc_o), 64'h108);
        check("byp_v1", 64'(bus.out_v1_o), 64'h2A);
        check("byp_busy1", 64'(bus.out_busy1_o), 64'd0);

        // Double rename of x7; commit of the older one keeps x7 busy
        drive(32'h200, 5'd0, 5'd0, 5'd7, 32'h0);
        tick();
        drive(32'h204, 5'd7, 5'd0, 5'd7, 32'h0);
        tick();
        check("r7_q1", 64'(bus.out_q1_o), 64'h200);
        check("r7_busy1", 64'(bus.out_busy1_o), 64'd1);
        bus.in_valid_i = 1'b0;
        commit(1'b1, 5'd7, 32'h200, 32'h77);
        tick();
        commit(1'b0, 5'd0, 32'h0, 32'h0);
        check("idle_valid", 64'(bus.out_valid_o), 64'd0);
        drive(32'h208, 5'd7, 5'd0, 5'd0, 32'h0);
        tick();
        check("r7b_busy1", 64'(bus.out_busy1_o), 64'd1);
        check("r7b_q1", 64'(bus.out_q1_o), 64'h204);

        // Flush with busy x3 and a pending packet; commit in flush cycle is dropped
        drive(32'h300, 5'd0, 5'd0, 5'd3, 32'h0);
        tick();
        check("f_pend", 64'(bus.out_valid_o), 64'd1);
        bus.in_valid_i = 1'b1;
        bus.flush_i    = 1'b1;
        commit(1'b1, 5'd3, 32'h300, 32'h55);
        #1;
        check("f_ready", 64'(bus.in_ready_o), 64'd0);
        tick();
        bus.flush_i = 1'b0;
        commit(1'b0, 5'd0, 32'h0, 32'h0);
        check("f_valid", 64'(bus.out_valid_o), 64'd0);
        drive(32'h30C, 5'd3, 5'd7, 5'd0, 32'h0);
        tick();
        check("f_busy", 64'({bus.out_busy1_o, bus.out_busy2_o}), 64'd0);
        check("f_v1", 64'(bus.out_v1_o), 64'd0);
        check("f_v2", 64'(bus.out_v2_o), 64'h77);

        // ROB stall holds the packet for three cycles
        drive(32'h400, 5'd0, 5'd0, 5'd9, 32'h1);
        tick();
        check("s_pc0", 64'(bus.out_pc_o), 64'h400);
        drive(32'h404, 5'd9, 5'd0, 5'd10, 32'h2);
        bus.rob_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("s_ready", 64'(bus.in_ready_o), 64'd0);
            tick();
            check("s_valid", 64'(bus.out_valid_o), 64'd1);
            check("s_pc", 64'(bus.out_pc_o), 64'h400);
        end
        bus.rob_stall_i = 1'b0;
        #1;
        check("s_ready_rel", 64'(bus.in_ready_o), 64'd1);
        tick();
        check("s_pc_rel", 64'(bus.out_pc_o), 64'h404);
        check("s_q1_rel", 64'(bus.out_q1_o), 64'h400);

        // rd=0 never renames; self-reference reads pre-rename state
        drive(32'h500, 5'd0, 5'd0, 5'd0, 32'h0);
        tick();
        check("z_v1", 64'(bus.out_v1_o), 64'd0);
        drive(32'h504, 5'd0, 5'd11, 5'd11, 32'h0);
        tick();
        check("z_noren", 64'(bus.out_busy1_o), 64'd0);
        check("self_busy2", 64'(bus.out_busy2_o), 64'd0);
        drive(32'h508, 5'd11, 5'd0, 5'd0, 32'h0);
        tick();
        check("self_q1", 64'(bus.out_q1_o), 64'h504);
        bus.in_valid_i = 1'b0;
        tick();
        check("end_valid", 64'(bus.out_valid_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
